// File: rtl/spi_target_pkg.sv
// Shared constants and FSM states for the 40-bit register datagram.
// The motor-driver SPI master uses the same frame constants.
package spi_target_pkg;

    localparam int FRAME_BITS  = 40;
    localparam int WR_FLAG_BIT = FRAME_BITS - 1;
    localparam int STATUS_W    = 8;
    localparam int CNT_W       = 6;
    localparam int CNT_SAT     = FRAME_BITS + 1;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        COMMIT
    } state_t;

    // Counts one past a full frame so overlong frames stay distinguishable.
    function automatic logic [CNT_W-1:0] cnt_inc(
        input logic [CNT_W-1:0] c
    );
        if (c >= CNT_W'(CNT_SAT)) begin
            return c;
        end
        return c + CNT_W'(1);
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchroniser with a third flop for rise/fall pulse detection.
// EDGE_EN=0 keeps the pulse outputs tied low (data-only lines).
module spi_sync_edge #(
    parameter bit EDGE_EN = 1'b1
) (
    input  logic clk_in,
    input  logic reset_in,
    input  logic async_in,
    output logic sync_out,
    output logic rise_out,
    output logic fall_out
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_prev <= 1'b0;
        end else begin
            r_meta <= async_in;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign sync_out = r_sync;
    assign rise_out = EDGE_EN & r_sync & ~r_prev;
    assign fall_out = EDGE_EN & ~r_sync & r_prev;

endmodule

// File: rtl/spi_target.sv
// SPI mode-3 responder for the 40-bit register datagram with a small bank.
// Define SPI_TARGET_RDCLR_EN to make register 1 clear-on-read over SPI.
module spi_target
    import spi_target_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 7,
    parameter int NUM_REGS   = 16
) (
    input  logic                  clk_in,
    input  logic                  reset_in,
    input  logic                  sck_in,
    input  logic                  cs_n_in,
    input  logic                  sdi_in,
    output logic                  sdo_out,
    output logic                  sdo_oe_out,
    input  logic [STATUS_W-1:0]   status_in,
    input  logic [ADDR_WIDTH-1:0] host_addr_in,
    output logic [DATA_WIDTH-1:0] host_rdata_out,
    output logic                  wr_valid_out,
    output logic [ADDR_WIDTH-1:0] wr_addr_out,
    output logic [DATA_WIDTH-1:0] wr_data_out,
    output logic                  frame_err_out
);

    localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    logic w_sck_sync_unused;
    logic w_sck_rise;
    logic w_sck_fall;
    logic w_cs_sync;
    logic w_cs_rise;
    logic w_cs_fall;
    logic w_sdi_sync;
    logic w_sdi_rise_unused;
    logic w_sdi_fall_unused;

    spi_sync_edge #(.EDGE_EN(1'b1)) u_sck_sync (
        .clk_in   (clk_in),
        .reset_in (reset_in),
        .async_in (sck_in),
        .sync_out (w_sck_sync_unused),
        .rise_out (w_sck_rise),
        .fall_out (w_sck_fall)
    );

    spi_sync_edge #(.EDGE_EN(1'b1)) u_cs_sync (
        .clk_in   (clk_in),
        .reset_in (reset_in),
        .async_in (cs_n_in),
        .sync_out (w_cs_sync),
        .rise_out (w_cs_rise),
        .fall_out (w_cs_fall)
    );

    spi_sync_edge #(.EDGE_EN(1'b0)) u_sdi_sync (
        .clk_in   (clk_in),
        .reset_in (reset_in),
        .async_in (sdi_in),
        .sync_out (w_sdi_sync),
        .rise_out (w_sdi_rise_unused),
        .fall_out (w_sdi_fall_unused)
    );

    state_t r_state;
    state_t w_next;

    logic                  r_armed;
    logic                  r_fall_pend;
    logic [CNT_W-1:0]      r_cnt;
    logic [FRAME_BITS-1:0] r_tx;
    logic [FRAME_BITS-1:0] r_rx;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [DATA_WIDTH-1:0] r_bank [NUM_REGS];
    logic                  r_sdo;
    logic                  r_sdo_oe;
    logic                  r_wr_valid;
    logic [ADDR_WIDTH-1:0] r_wr_addr;
    logic [DATA_WIDTH-1:0] r_wr_data;
    logic                  r_frame_err;
    logic [DATA_WIDTH-1:0] r_host_rdata;

    logic                  w_load;
    logic                  w_end;
    logic                  w_commit;
    logic                  w_frame_ok;
    logic [ADDR_WIDTH-1:0] w_rx_addr;
    logic [DATA_WIDTH-1:0] w_rx_data;
    logic                  w_rx_wr;
    logic                  w_addr_ok;
    logic [IDX_W-1:0]      w_idx;
    logic                  w_do_write;
    logic [DATA_WIDTH-1:0] w_rd_data;

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        w_load   = 1'b0;
        w_end    = 1'b0;
        w_commit = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (r_armed && !w_cs_sync &&
                    (w_cs_fall || r_fall_pend)) begin
                    w_next = SHIFT;
                    w_load = 1'b1;
                end
            end
            SHIFT: begin
                if (w_cs_rise) begin
                    w_next = COMMIT;
                    w_end  = 1'b1;
                end
            end
            COMMIT: begin
                w_next   = IDLE;
                w_commit = 1'b1;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    assign w_frame_ok = (r_cnt == CNT_W'(FRAME_BITS));
    assign w_rx_addr  = r_rx[FRAME_BITS-2 -: ADDR_WIDTH];
    assign w_rx_data  = r_rx[DATA_WIDTH-1:0];
    assign w_rx_wr    = r_rx[WR_FLAG_BIT];
    assign w_addr_ok  = int'(w_rx_addr) < NUM_REGS;
    assign w_idx      = w_rx_addr[IDX_W-1:0];
    assign w_do_write = w_commit & w_frame_ok & w_rx_wr & w_addr_ok;

    assign w_rd_data = (int'(r_rd_ptr) < NUM_REGS)
                     ? r_bank[r_rd_ptr[IDX_W-1:0]]
                     : '0;

`ifdef SPI_TARGET_RDCLR_EN
    logic w_rdclr;
    // Register 1 clears once its value has gone out, unless this frame rewrites it.
    assign w_rdclr = w_commit & w_frame_ok &
                     (r_rd_ptr == ADDR_WIDTH'(1)) &
                     ~(w_do_write && (w_idx == IDX_W'(1)));
`endif

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            r_armed     <= 1'b0;
            r_fall_pend <= 1'b0;
            r_cnt       <= '0;
            r_tx        <= '0;
            r_rx        <= '0;
            r_rd_ptr    <= '0;
            r_sdo       <= 1'b1;
            r_sdo_oe    <= 1'b0;
            r_wr_valid  <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
            r_frame_err <= 1'b0;
        end else begin
            r_wr_valid  <= 1'b0;
            r_frame_err <= 1'b0;
            r_armed     <= r_armed | w_cs_sync;
            if (r_state == COMMIT && w_cs_fall) begin
                r_fall_pend <= 1'b1;
            end else if (r_state == IDLE) begin
                r_fall_pend <= 1'b0;
            end
            if (w_load) begin
                r_tx     <= {status_in, w_rd_data};
                r_cnt    <= '0;
                r_sdo_oe <= 1'b1;
            end
            if (r_state == SHIFT) begin
                if (w_sck_fall) begin
                    r_sdo <= r_tx[FRAME_BITS-1];
                    r_tx  <= r_tx << 1;
                end
                if (w_sck_rise) begin
                    r_rx  <= {r_rx[FRAME_BITS-2:0], w_sdi_sync};
                    r_cnt <= cnt_inc(r_cnt);
                end
            end
            if (w_end) begin
                r_sdo_oe <= 1'b0;
                r_sdo    <= 1'b1;
            end
            if (w_commit) begin
                if (w_frame_ok) begin
                    r_rd_ptr <= w_rx_addr;
                end else begin
                    r_frame_err <= 1'b1;
                end
            end
            if (w_do_write) begin
                r_wr_valid <= 1'b1;
                r_wr_addr  <= w_rx_addr;
                r_wr_data  <= w_rx_data;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_bank[i] <= '0;
            end
        end else begin
`ifdef SPI_TARGET_RDCLR_EN
            if (w_rdclr) begin
                r_bank[1] <= '0;
            end
`endif
            if (w_do_write) begin
                r_bank[w_idx] <= w_rx_data;
            end
        end
    end

    // Sampled before any same-cycle bank write lands, so host sees the old value.
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            r_host_rdata <= '0;
        end else if (int'(host_addr_in) < NUM_REGS) begin
            r_host_rdata <= r_bank[host_addr_in[IDX_W-1:0]];
        end else begin
            r_host_rdata <= '0;
        end
    end

    assign sdo_out        = r_sdo;
    assign sdo_oe_out     = r_sdo_oe;
    assign wr_valid_out   = r_wr_valid;
    assign wr_addr_out    = r_wr_addr;
    assign wr_data_out    = r_wr_data;
    assign frame_err_out  = r_frame_err;
    assign host_rdata_out = r_host_rdata;

endmodule

// File: tb/tb_spi_target.sv
// Scoreboard bench for spi_target: drivers queue expectations,
// a monitor compares write pulses, frame errors, SPI responses and host reads.
module tb_spi_target;

    logic        clk_in = 1'b0;
    logic        reset_in = 1'b1;
    logic        sck_in = 1'b1;
    logic        cs_n_in = 1'b0;
    logic        sdi_in = 1'b0;
    logic        sdo_out;
    logic        sdo_oe_out;
    logic [7:0]  status_in = 8'hA5;
    logic [6:0]  host_addr_in = 7'd0;
    logic [31:0] host_rdata_out;
    logic        wr_valid_out;
    logic [6:0]  wr_addr_out;
    logic [31:0] wr_data_out;
    logic        frame_err_out;

    spi_target dut (
        .clk_in         (clk_in),
        .reset_in       (reset_in),
        .sck_in         (sck_in),
        .cs_n_in        (cs_n_in),
        .sdi_in         (sdi_in),
        .sdo_out        (sdo_out),
        .sdo_oe_out     (sdo_oe_out),
        .status_in      (status_in),
        .host_addr_in   (host_addr_in),
        .host_rdata_out (host_rdata_out),
        .wr_valid_out   (wr_valid_out),
        .wr_addr_out    (wr_addr_out),
        .wr_data_out    (wr_data_out),
        .frame_err_out  (frame_err_out)
    );

    always #20 clk_in = ~clk_in;

    int n_pass = 0;
    int n_tot  = 0;

    logic [38:0] q_wr[$];
    bit          q_err[$];
    logic [39:0] q_rsp_exp[$];
    logic [39:0] q_rsp_got[$];
    logic [31:0] q_host[$];
    int          host_req = 0;
    int          host_seen = 0;

`ifdef SPI_TARGET_RDCLR_EN
    localparam logic [31:0] REG1_AFTER = 32'h0;
`else
    localparam logic [31:0] REG1_AFTER = 32'h5;
`endif

    task automatic chk(input string name, input logic [63:0] got,
                       input logic [63:0] exp);
        n_tot++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    logic [38:0] m_wr;
    logic [39:0] m_exp;
    logic [39:0] m_got;
    logic [31:0] m_host;

    always @(posedge clk_in) begin
        #1;
        if (wr_valid_out) begin
            if (q_wr.size() == 0) begin
                n_tot++;
                $display("FAIL wr_unexpected: got addr %h data %h, expected none",
                         wr_addr_out, wr_data_out);
            end else begin
                m_wr = q_wr.pop_front();
                chk("wr_commit", {25'd0, wr_addr_out, wr_data_out},
                    {25'd0, m_wr});
            end
        end
        if (frame_err_out) begin
            if (q_err.size() == 0) begin
                n_tot++;
                $display("FAIL err_unexpected: got pulse, expected none");
            end else begin
                void'(q_err.pop_front());
                n_tot++;
                n_pass++;
            end
        end
        if (q_rsp_got.size() > 0) begin
            m_got = q_rsp_got.pop_front();
            if (q_rsp_exp.size() == 0) begin
                n_tot++;
                $display("FAIL rsp_unexpected: got %h, expected none", m_got);
            end else begin
                m_exp = q_rsp_exp.pop_front();
                chk("spi_rsp", {24'd0, m_got}, {24'd0, m_exp});
            end
        end
        if (host_req != host_seen) begin
            host_seen++;
            m_host = q_host.pop_front();
            chk("host_rd", {32'd0, host_rdata_out}, {32'd0, m_host});
        end
    end

    task automatic shift_bits(input logic [47:0] w, input int n,
                              output logic [47:0] cap);
        cap = '0;
        for (int i = n - 1; i >= 0; i--) begin
            sck_in = 1'b0;
            sdi_in = w[i];
            repeat (8) @(negedge clk_in);
            sck_in = 1'b1;
            cap = {cap[46:0], sdo_out};
            repeat (8) @(negedge clk_in);
        end
    endtask

    task automatic frame(input logic [47:0] w, input int n,
                         input bit rsp_chk, input logic [39:0] exp);
        logic [47:0] cap;
        if (rsp_chk) q_rsp_exp.push_back(exp);
        cs_n_in = 1'b0;
        repeat (8) @(negedge clk_in);
        chk("oe_active", {63'd0, sdo_oe_out}, 64'd1);
        shift_bits(w, n, cap);
        repeat (4) @(negedge clk_in);
        cs_n_in = 1'b1;
        if (rsp_chk) q_rsp_got.push_back(cap[39:0]);
        repeat (12) @(negedge clk_in);
        chk("oe_idle", {63'd0, sdo_oe_out}, 64'd0);
    endtask

    task automatic host_rd(input logic [6:0] a, input logic [31:0] exp);
        @(negedge clk_in);
        host_addr_in = a;
        q_host.push_back(exp);
        host_req++;
        repeat (2) @(negedge clk_in);
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_sdo"},   {63'd0, sdo_out},        64'd1);
        chk({tag, "_oe"},    {63'd0, sdo_oe_out},     64'd0);
        chk({tag, "_wrv"},   {63'd0, wr_valid_out},   64'd0);
        chk({tag, "_err"},   {63'd0, frame_err_out},  64'd0);
        chk({tag, "_wra"},   {57'd0, wr_addr_out},    64'd0);
        chk({tag, "_wrd"},   {32'd0, wr_data_out},    64'd0);
        chk({tag, "_host"},  {32'd0, host_rdata_out}, 64'd0);
    endtask

    initial begin
        #(40 * 60000);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [47:0] cap;
        repeat (4) @(negedge clk_in);
        chk_reset_outs("reset");
        reset_in = 1'b0;
        // CS already low when reset releases: must stay ignored.
        shift_bits(48'h5, 3, cap);
        chk("cs_low_at_release", {63'd0, sdo_oe_out}, 64'd0);
        cs_n_in = 1'b1;
        repeat (16) @(negedge clk_in);

        q_wr.push_back({7'h03, 32'hDEADBEEF});
        frame(48'h83DEADBEEF, 40, 1'b1, 40'hA5_00000000);
        host_rd(7'h03, 32'hDEADBEEF);
        frame(48'h0300000000, 40, 1'b1, 40'hA5_DEADBEEF);
        frame(48'h0000000000, 40, 1'b1, 40'hA5_DEADBEEF);

        status_in = 8'h3C;
        frame(48'h0000000000, 40, 1'b1, 40'h3C_00000000);
        q_err.push_back(1'b1);
        frame(48'h0042888888, 39, 1'b0, 40'h0);
        q_err.push_back(1'b1);
        frame(48'h10A44444444, 41, 1'b0, 40'h0);
        frame(48'h0300000000, 40, 1'b1, 40'h3C_00000000);
        frame(48'hA012345678, 40, 1'b1, 40'h3C_DEADBEEF);
        frame(48'h2000000000, 40, 1'b1, 40'h3C_00000000);
        host_rd(7'h05, 32'h0);
        host_rd(7'h03, 32'hDEADBEEF);
        host_rd(7'h20, 32'h0);

        // Reset in the middle of a write frame with CS held low.
        cs_n_in = 1'b0;
        repeat (8) @(negedge clk_in);
        shift_bits(48'h84CA, 16, cap);
        reset_in = 1'b1;
        repeat (3) @(negedge clk_in);
        chk_reset_outs("midrst");
        reset_in = 1'b0;
        shift_bits(48'hFEF00D, 24, cap);
        chk("midrst_cs_ignored", {63'd0, sdo_oe_out}, 64'd0);
        cs_n_in = 1'b1;
        repeat (16) @(negedge clk_in);
        host_rd(7'h03, 32'h0);

        q_wr.push_back({7'h01, 32'h00000005});
        frame(48'h8100000005, 40, 1'b1, 40'h3C_00000000);
        frame(48'h0100000000, 40, 1'b1, 40'h3C_00000005);
        frame(48'h0100000000, 40, 1'b1, {8'h3C, REG1_AFTER});
        host_rd(7'h01, REG1_AFTER);

        repeat (20) @(negedge clk_in);
        chk("wr_q_drained",  {32'd0, q_wr.size()},      64'd0);
        chk("err_q_drained", {32'd0, q_err.size()},     64'd0);
        chk("rsp_q_drained", {32'd0, q_rsp_exp.size()}, 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
